// File: rtl/branch_predict_unit.sv
// Static predecode/predict stage for a 2-slot LoongArch32 fetch packet; registered outputs feed decode.
// Optional macro BPU_BTFN_EN: backward conditional branches predicted taken (default: all conditionals not taken).
module branch_predict_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [31:0] pc_1_i,
  input  logic [31:0] pc_2_i,
  input  logic [31:0] inst_1_i,
  input  logic [31:0] inst_2_i,
  output logic [31:0] pc_1_o,
  output logic [31:0] pc_2_o,
  output logic [31:0] inst_1_o,
  output logic [31:0] inst_2_o,
  output logic        is_branch_1,
  output logic        is_branch_2,
  output logic        taken_or_not,
  output logic [31:0] branch_target,
  output logic        fetch_inst_1_en,
  output logic        fetch_inst_2_en
);

  typedef enum logic [1:0] {
    BR_NONE,
    BR_UNCOND,
    BR_INDIRECT,
    BR_COND
  } br_kind_e;

  function automatic br_kind_e decode_kind(input logic [5:0] op);
    case (op)
      6'b010100, 6'b010101: decode_kind = BR_UNCOND;
      6'b010011:            decode_kind = BR_INDIRECT;
      6'b010110, 6'b010111, 6'b011000,
      6'b011001, 6'b011010, 6'b011011,
      6'b010000, 6'b010001: decode_kind = BR_COND;
      default:              decode_kind = BR_NONE;
    endcase
  endfunction

  // Byte offset: immediate fields reassembled per format, sign-extended, scaled by 4.
  function automatic logic signed [31:0] branch_offset(input logic [31:0] inst);
    case (inst[31:26])
      6'b010100, 6'b010101:
        branch_offset = $signed({{4{inst[9]}}, inst[9:0], inst[25:10], 2'b00});
      6'b010000, 6'b010001:
        branch_offset = $signed({{9{inst[4]}}, inst[4:0], inst[25:10], 2'b00});
      default:
        branch_offset = $signed({{14{inst[25]}}, inst[25:10], 2'b00});
    endcase
  endfunction

  function automatic logic predict_taken(input br_kind_e kind, input logic signed [31:0] offs);
    case (kind)
      BR_UNCOND: predict_taken = 1'b1;
`ifdef BPU_BTFN_EN
      BR_COND:   predict_taken = offs[31];
`else
      BR_COND:   predict_taken = 1'b0 & offs[31];
`endif
      default:   predict_taken = 1'b0;
    endcase
  endfunction

  // Stage p0: combinational predecode and packet resolution on the fetch inputs
  br_kind_e           kind_1_p0, kind_2_p0;
  logic signed [31:0] offs_1_p0, offs_2_p0;
  logic signed [31:0] tgt_1_p0, tgt_2_p0;
  logic               tk_1_p0, tk_2_p0;
  logic               pkt_taken_p0;
  logic        [31:0] pkt_target_p0;
  logic               en_2_p0;

  always_comb begin
    kind_1_p0     = decode_kind(inst_1_i[31:26]);
    kind_2_p0     = decode_kind(inst_2_i[31:26]);
    offs_1_p0     = branch_offset(inst_1_i);
    offs_2_p0     = branch_offset(inst_2_i);
    tgt_1_p0      = $signed(pc_1_i) + offs_1_p0;
    tgt_2_p0      = $signed(pc_2_i) + offs_2_p0;
    tk_1_p0       = predict_taken(kind_1_p0, offs_1_p0);
    tk_2_p0       = predict_taken(kind_2_p0, offs_2_p0);
    pkt_taken_p0  = tk_1_p0 | tk_2_p0;
    pkt_target_p0 = 32'd0;
    if (tk_1_p0)
      pkt_target_p0 = $unsigned(tgt_1_p0);
    else if (tk_2_p0)
      pkt_target_p0 = $unsigned(tgt_2_p0);
    en_2_p0       = ~tk_1_p0;
  end

  // Stage p1: output registers toward decode and the PC generator
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_1_o          <= 32'd0;
      pc_2_o          <= 32'd0;
      inst_1_o        <= 32'd0;
      inst_2_o        <= 32'd0;
      is_branch_1     <= 1'b0;
      is_branch_2     <= 1'b0;
      taken_or_not    <= 1'b0;
      branch_target   <= 32'd0;
      fetch_inst_1_en <= 1'b0;
      fetch_inst_2_en <= 1'b0;
    end else if (flush) begin
      pc_1_o          <= 32'd0;
      pc_2_o          <= 32'd0;
      inst_1_o        <= 32'd0;
      inst_2_o        <= 32'd0;
      is_branch_1     <= 1'b0;
      is_branch_2     <= 1'b0;
      taken_or_not    <= 1'b0;
      branch_target   <= 32'd0;
      fetch_inst_1_en <= 1'b0;
      fetch_inst_2_en <= 1'b0;
    end else begin
      pc_1_o          <= pc_1_i;
      pc_2_o          <= pc_2_i;
      inst_1_o        <= inst_1_i;
      inst_2_o        <= inst_2_i;
      is_branch_1     <= (kind_1_p0 != BR_NONE);
      is_branch_2     <= (kind_2_p0 != BR_NONE);
      taken_or_not    <= pkt_taken_p0;
      branch_target   <= pkt_target_p0;
      fetch_inst_1_en <= 1'b1;
      fetch_inst_2_en <= en_2_p0;
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit with hand-computed expectations.
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [31:0] pc_1_i, pc_2_i, inst_1_i, inst_2_i;
  logic [31:0] pc_1_o, pc_2_o, inst_1_o, inst_2_o;
  logic        is_branch_1, is_branch_2, taken_or_not;
  logic [31:0] branch_target;
  logic        fetch_inst_1_en, fetch_inst_2_en;

  int compared   = 0;
  int mismatched = 0;

  branch_predict_unit dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .pc_1_i          (pc_1_i),
    .pc_2_i          (pc_2_i),
    .inst_1_i        (inst_1_i),
    .inst_2_i        (inst_2_i),
    .pc_1_o          (pc_1_o),
    .pc_2_o          (pc_2_o),
    .inst_1_o        (inst_1_o),
    .inst_2_o        (inst_2_o),
    .is_branch_1     (is_branch_1),
    .is_branch_2     (is_branch_2),
    .taken_or_not    (taken_or_not),
    .branch_target   (branch_target),
    .fetch_inst_1_en (fetch_inst_1_en),
    .fetch_inst_2_en (fetch_inst_2_en)
  );

  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag,
                         input logic [31:0] e_pc1, input logic [31:0] e_pc2,
                         input logic [31:0] e_i1, input logic [31:0] e_i2,
                         input logic e_br1, input logic e_br2, input logic e_tk,
                         input logic [31:0] e_tgt, input logic e_en1, input logic e_en2);
    chk({tag, ".pc_1_o"},          pc_1_o,                 e_pc1);
    chk({tag, ".pc_2_o"},          pc_2_o,                 e_pc2);
    chk({tag, ".inst_1_o"},        inst_1_o,               e_i1);
    chk({tag, ".inst_2_o"},        inst_2_o,               e_i2);
    chk({tag, ".is_branch_1"},     {31'd0, is_branch_1},   {31'd0, e_br1});
    chk({tag, ".is_branch_2"},     {31'd0, is_branch_2},   {31'd0, e_br2});
    chk({tag, ".taken_or_not"},    {31'd0, taken_or_not},  {31'd0, e_tk});
    chk({tag, ".branch_target"},   branch_target,          e_tgt);
    chk({tag, ".fetch_inst_1_en"}, {31'd0, fetch_inst_1_en}, {31'd0, e_en1});
    chk({tag, ".fetch_inst_2_en"}, {31'd0, fetch_inst_2_en}, {31'd0, e_en2});
  endtask

  task automatic chk_zero(input string tag);
    chk_all(tag, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
  endtask

  // Apply inputs mid-cycle, then sample just after the next rising edge.
  task automatic step(input logic [31:0] p1, input logic [31:0] p2,
                      input logic [31:0] i1, input logic [31:0] i2);
    @(negedge clk);
    pc_1_i   = p1;
    pc_2_i   = p2;
    inst_1_i = i1;
    inst_2_i = i2;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst      = 1'b0;
    flush    = 1'b0;
    pc_1_i   = 32'h4;
    pc_2_i   = 32'h8;
    inst_1_i = 32'h1;
    inst_2_i = 32'h2;

    #3;
    chk_zero("reset_async");
    @(posedge clk);
    #1;
    chk_zero("reset_held");

    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_all("t1_plain", 32'h4, 32'h8, 32'h1, 32'h2, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1);

    step(32'hC, 32'h10, 32'h5000_0001, 32'h2);
    chk_all("t2_b_slot1", 32'hC, 32'h10, 32'h5000_0001, 32'h2,
            1'b1, 1'b0, 1'b1, 32'h0004_000C, 1'b1, 1'b0);

    step(32'hC, 32'h10, 32'h2, 32'h5000_0001);
    chk_all("t3_b_slot2", 32'hC, 32'h10, 32'h2, 32'h5000_0001,
            1'b0, 1'b1, 1'b1, 32'h0004_0010, 1'b1, 1'b1);

    step(32'h100, 32'h104, 32'h5BFF_FC00, 32'h2);
`ifdef BPU_BTFN_EN
    chk_all("t4_beq_back", 32'h100, 32'h104, 32'h5BFF_FC00, 32'h2,
            1'b1, 1'b0, 1'b1, 32'hFC, 1'b1, 1'b0);
`else
    chk_all("t4_beq_back", 32'h100, 32'h104, 32'h5BFF_FC00, 32'h2,
            1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
`endif

    step(32'hC, 32'h10, 32'h4C00_0000, 32'h5000_0001);
    chk_all("t5_jirl_b", 32'hC, 32'h10, 32'h4C00_0000, 32'h5000_0001,
            1'b1, 1'b1, 1'b1, 32'h0004_0010, 1'b1, 1'b1);

    // BL +0x40 in slot 1 squashes the B in slot 2
    step(32'h200, 32'h204, 32'h5400_4000, 32'h5000_0001);
    chk_all("t6_bl_squash", 32'h200, 32'h204, 32'h5400_4000, 32'h5000_0001,
            1'b1, 1'b1, 1'b1, 32'h240, 1'b1, 1'b0);

    // B with offs26 = -1 (byte offset -4)
    step(32'h1000, 32'h1004, 32'h53FF_FFFF, 32'h2);
    chk_all("t7_b_neg", 32'h1000, 32'h1004, 32'h53FF_FFFF, 32'h2,
            1'b1, 1'b0, 1'b1, 32'hFFC, 1'b1, 1'b0);

    // BNEZ in slot 2 with offs21 = -8 (byte offset -32)
    step(32'h2000, 32'h2004, 32'h2, 32'h47FF_E01F);
`ifdef BPU_BTFN_EN
    chk_all("t8_bnez_back", 32'h2000, 32'h2004, 32'h2, 32'h47FF_E01F,
            1'b0, 1'b1, 1'b1, 32'h1FE4, 1'b1, 1'b1);
`else
    chk_all("t8_bnez_back", 32'h2000, 32'h2004, 32'h2, 32'h47FF_E01F,
            1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
`endif

    // Forward BLT in slot 1 is never taken, so the B in slot 2 redirects
    step(32'h3000, 32'h3004, 32'h6000_1000, 32'h5000_0001);
    chk_all("t9_blt_fwd", 32'h3000, 32'h3004, 32'h6000_1000, 32'h5000_0001,
            1'b1, 1'b1, 1'b1, 32'h0004_3004, 1'b1, 1'b1);

    step(32'h40, 32'h44, 32'h7000_0000, 32'h4800_0000);
    chk_all("t10_nonbr", 32'h40, 32'h44, 32'h7000_0000, 32'h4800_0000,
            1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1);

    @(negedge clk);
    flush = 1'b1;
    step(32'hC, 32'h10, 32'h5000_0001, 32'h2);
    chk_zero("t11_flush");

    @(negedge clk);
    flush = 1'b0;
    step(32'hC, 32'h10, 32'h5000_0001, 32'h2);
    chk_all("t12_after_flush", 32'hC, 32'h10, 32'h5000_0001, 32'h2,
            1'b1, 1'b0, 1'b1, 32'h0004_000C, 1'b1, 1'b0);

    #2;
    rst = 1'b0;
    #1;
    chk_zero("t13_async_mid");
    @(posedge clk);
    #1;
    chk_zero("t13_reset_held");

    @(negedge clk);
    rst = 1'b1;
    step(32'h4, 32'h8, 32'h1, 32'h2);
    chk_all("t14_after_reset", 32'h4, 32'h8, 32'h1, 32'h2,
            1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
